// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: data/index widths,
// the WB-to-DE bundle width, the write-request record and the grant-source encoding.
package wb_port_arbiter_pkg;

  localparam int DBITS       = 32;
  localparam int REGNOBITS   = 5;
  localparam int WB_DE_BUS_W = 1 + REGNOBITS + DBITS;

  typedef struct packed {
    logic                 wr_en;
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LU   = 2'd2
  } gnt_src_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Small FIFO buffering long-latency-unit results; writes to x0 are dropped at the door.
// Optional macro WBARB_FWD_EN adds an associative youngest-match lookup on the contents.
module wb_lu_fifo #(
  parameter int DBITS     = wb_port_arbiter_pkg::DBITS,
  parameter int REGNOBITS = wb_port_arbiter_pkg::REGNOBITS,
  parameter int QDEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push_valid,
  input  logic [REGNOBITS-1:0]       i_push_regno,
  input  logic [DBITS-1:0]           i_push_val,
  input  logic                       i_pop,
  output logic                       o_ready,
  output logic                       o_empty,
  output logic [REGNOBITS-1:0]       o_head_regno,
  output logic [DBITS-1:0]           o_head_val,
  output logic [$clog2(QDEPTH):0]    o_count
`ifdef WBARB_FWD_EN
  ,
  input  logic [REGNOBITS-1:0]       i_fwd_regno,
  output logic                       o_fwd_hit,
  output logic [DBITS-1:0]           o_fwd_val
`endif
);
  import wb_port_arbiter_pkg::*;

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [REGNOBITS-1:0] r_regno [QDEPTH];
  logic [DBITS-1:0]     r_val   [QDEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_push;
  logic                 w_pop;

  // Readiness looks only at the registered count, so a full FIFO refuses a push even when popping.
  assign o_ready      = (r_count < CW'(QDEPTH));
  assign o_empty      = (r_count == '0);
  assign o_count      = r_count;
  assign o_head_regno = r_regno[r_rd_ptr];
  assign o_head_val   = r_val[r_rd_ptr];
  assign w_push       = i_push_valid && o_ready && (i_push_regno != '0);
  assign w_pop        = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_regno[r_wr_ptr] <= i_push_regno;
      r_val[r_wr_ptr]   <= i_push_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WBARB_FWD_EN
  // Bit gi of the match vector is the entry gi slots behind the head (gi=0 is oldest).
  logic [QDEPTH-1:0] w_match;

  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_cmp
      logic [AW-1:0] w_idx;
      assign w_idx        = r_rd_ptr + AW'(gi);
      assign w_match[gi]  = (CW'(gi) < r_count) && (i_fwd_regno != '0) &&
                            (r_regno[w_idx] == i_fwd_regno);
    end
  endgenerate

  always_comb begin
    o_fwd_hit = |w_match;
    o_fwd_val = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_match[i]) o_fwd_val = r_val[r_rd_ptr + AW'(i)];
    end
  end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered
// LU results; pipeline wins unless the FIFO head has aged out. Optional macro: WBARB_FWD_EN.
module wb_port_arbiter #(
  parameter int DBITS        = wb_port_arbiter_pkg::DBITS,
  parameter int REGNOBITS    = wb_port_arbiter_pkg::REGNOBITS,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pipe_wr_en,
  input  logic [REGNOBITS-1:0]    pipe_wregno,
  input  logic [DBITS-1:0]        pipe_regval,
  output logic                    pipe_stall,
  input  logic                    lu_valid,
  input  logic [REGNOBITS-1:0]    lu_wregno,
  input  logic [DBITS-1:0]        lu_regval,
  output logic                    lu_ready,
  output logic                    rf_wr_en,
  output logic [REGNOBITS-1:0]    rf_wregno,
  output logic [DBITS-1:0]        rf_wrval,
  output logic [$clog2(QDEPTH):0] q_count
`ifdef WBARB_FWD_EN
  ,
  input  logic [REGNOBITS-1:0]    fwd_regno,
  output logic                    fwd_hit,
  output logic [DBITS-1:0]        fwd_val
`endif
);
  import wb_port_arbiter_pkg::*;

  localparam int AGEW = $clog2(STARVE_LIMIT + 1);

  logic                 w_empty;
  logic [REGNOBITS-1:0] w_head_regno;
  logic [DBITS-1:0]     w_head_val;
  logic                 w_force;
  logic                 w_pipe_req;
  gnt_src_t             w_gnt;
  logic [AGEW-1:0]      r_age;
  logic                 r_wr_en;
  logic [REGNOBITS-1:0] r_wregno;
  logic [DBITS-1:0]     r_wrval;

  wb_lu_fifo #(
    .DBITS     (DBITS),
    .REGNOBITS (REGNOBITS),
    .QDEPTH    (QDEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (lu_valid),
    .i_push_regno (lu_wregno),
    .i_push_val   (lu_regval),
    .i_pop        (w_gnt == GNT_LU),
    .o_ready      (lu_ready),
    .o_empty      (w_empty),
    .o_head_regno (w_head_regno),
    .o_head_val   (w_head_val),
    .o_count      (q_count)
`ifdef WBARB_FWD_EN
    ,
    .i_fwd_regno  (fwd_regno),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_val    (fwd_val)
`endif
  );

  assign w_force    = (r_age == AGEW'(STARVE_LIMIT)) && !w_empty;
  // A pipeline write to x0 needs no slot, so it leaves the port free for the LU.
  assign w_pipe_req = pipe_wr_en && (pipe_wregno != '0);

  always_comb begin
    w_gnt      = GNT_NONE;
    pipe_stall = 1'b0;
    if (w_force) begin
      w_gnt      = GNT_LU;
      pipe_stall = pipe_wr_en;
    end else if (w_pipe_req) begin
      w_gnt = GNT_PIPE;
    end else if (!w_empty) begin
      w_gnt = GNT_LU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_empty || (w_gnt == GNT_LU)) begin
      r_age <= '0;
    end else if (r_age != AGEW'(STARVE_LIMIT)) begin
      r_age <= r_age + AGEW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en  <= 1'b0;
      r_wregno <= '0;
      r_wrval  <= '0;
    end else begin
      r_wr_en <= (w_gnt != GNT_NONE);
      case (w_gnt)
        GNT_PIPE: begin
          r_wregno <= pipe_wregno;
          r_wrval  <= pipe_regval;
        end
        GNT_LU: begin
          r_wregno <= w_head_regno;
          r_wrval  <= w_head_val;
        end
        default: begin
          r_wregno <= r_wregno;
          r_wrval  <= r_wrval;
        end
      endcase
    end
  end

  assign rf_wr_en  = r_wr_en;
  assign rf_wregno = r_wregno;
  assign rf_wrval  = r_wrval;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Build with WBARB_FWD_EN to cover forwarding.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int QD = 4;
  localparam int SL = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pipe_wr_en;
  logic [REGNOBITS-1:0] pipe_wregno;
  logic [DBITS-1:0]     pipe_regval;
  logic                 pipe_stall;
  logic                 lu_valid;
  logic [REGNOBITS-1:0] lu_wregno;
  logic [DBITS-1:0]     lu_regval;
  logic                 lu_ready;
  logic                 rf_wr_en;
  logic [REGNOBITS-1:0] rf_wregno;
  logic [DBITS-1:0]     rf_wrval;
  logic [2:0]           q_count;
`ifdef WBARB_FWD_EN
  logic [REGNOBITS-1:0] fwd_regno;
  logic                 fwd_hit;
  logic [DBITS-1:0]     fwd_val;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: LU queue, head age, expected registered write port.
  wr_req_t              mq[$];
  int                   m_age;
  logic                 m_en;
  logic [REGNOBITS-1:0] m_regno;
  logic [DBITS-1:0]     m_val;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DBITS(DBITS), .REGNOBITS(REGNOBITS), .QDEPTH(QD), .STARVE_LIMIT(SL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_wr_en  (pipe_wr_en),
    .pipe_wregno (pipe_wregno),
    .pipe_regval (pipe_regval),
    .pipe_stall  (pipe_stall),
    .lu_valid    (lu_valid),
    .lu_wregno   (lu_wregno),
    .lu_regval   (lu_regval),
    .lu_ready    (lu_ready),
    .rf_wr_en    (rf_wr_en),
    .rf_wregno   (rf_wregno),
    .rf_wrval    (rf_wrval),
    .q_count     (q_count)
`ifdef WBARB_FWD_EN
    ,
    .fwd_regno   (fwd_regno),
    .fwd_hit     (fwd_hit),
    .fwd_val     (fwd_val)
`endif
  );

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic clk_step();
    bit      emp, frc, ptake, ltake, acc;
    wr_req_t e;
    emp   = (mq.size() == 0);
    frc   = (m_age == SL) && !emp;
    ptake = !frc && pipe_wr_en && (pipe_wregno != 0);
    ltake = !emp && !ptake;
    acc   = lu_valid && (mq.size() < QD) && (lu_wregno != 0);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_age = 0; m_en = 1'b0; m_regno = '0; m_val = '0;
    end else begin
      m_en = ptake || ltake;
      if (ptake) begin
        m_regno = pipe_wregno; m_val = pipe_regval;
      end else if (ltake) begin
        e = mq.pop_front();
        m_regno = e.wregno; m_val = e.regval;
      end
      if (emp || ltake) m_age = 0;
      else if (m_age < SL) m_age++;
      if (acc) begin
        e.wr_en = 1'b1; e.wregno = lu_wregno; e.regval = lu_regval;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wr_en = 1'b0; pipe_wregno = '0; pipe_regval = '0;
    lu_valid = 1'b0; lu_wregno = '0; lu_regval = '0;
`ifdef WBARB_FWD_EN
    fwd_regno = '0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    m_age = 0; m_en = 1'b0; m_regno = '0; m_val = '0;
    clk_step();
    clk_step();
    reset = 1'b0;
    #1;
    n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wr_en got=%b exp=0", rf_wr_en); end
    n_checks++; if (rf_wregno !== '0) begin n_fail++; $display("FAIL reset_rf_wregno got=%0d exp=0", rf_wregno); end
    n_checks++; if (rf_wrval !== '0) begin n_fail++; $display("FAIL reset_rf_wrval got=%h exp=0", rf_wrval); end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready got=%b exp=1", lu_ready); end
    n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
    $display("test_reset done");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      clk_step();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_rf_wr_en cyc=%0d got=%b exp=0", i, rf_wr_en); end
      n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_lu_ready cyc=%0d got=%b exp=1", i, lu_ready); end
      n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL idle_q_count cyc=%0d got=%0d exp=0", i, q_count); end
      n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL idle_pipe_stall cyc=%0d got=%b exp=0", i, pipe_stall); end
    end
    $display("test_idle done");
  endtask

  task automatic test_pipe_only();
    pipe_wr_en = 1'b1; pipe_wregno = 5'd5; pipe_regval = 32'h1234;
    #1;
    n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL pipe_stall got=%b exp=0", pipe_stall); end
    clk_step();
    n_checks++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL pipe_rf_wr_en got=%b exp=1", rf_wr_en); end
    n_checks++; if (rf_wregno !== 5'd5) begin n_fail++; $display("FAIL pipe_rf_wregno got=%0d exp=5", rf_wregno); end
    n_checks++; if (rf_wrval !== 32'h1234) begin n_fail++; $display("FAIL pipe_rf_wrval got=%h exp=1234", rf_wrval); end
    pipe_wr_en = 1'b0;
    clk_step();
    n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL pipe_idle_wr_en got=%b exp=0", rf_wr_en); end
    n_checks++; if (rf_wregno !== 5'd5 || rf_wrval !== 32'h1234) begin n_fail++; $display("FAIL pipe_hold got=%0d/%h exp=5/1234", rf_wregno, rf_wrval); end
    $display("test_pipe_only done");
  endtask

  task automatic test_lu_idle();
    lu_valid = 1'b1; lu_wregno = 5'd7; lu_regval = 32'hABCD;
    #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready got=%b exp=1", lu_ready); end
    clk_step();
    lu_valid = 1'b0;
    #1;
    n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL lu_q_count_1 got=%0d exp=1", q_count); end
    n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL lu_early_write got=%b exp=0", rf_wr_en); end
    clk_step();
    n_checks++; if (rf_wr_en !== 1'b1 || rf_wregno !== 5'd7 || rf_wrval !== 32'hABCD) begin
      n_fail++; $display("FAIL lu_write got=%b/%0d/%h exp=1/7/abcd", rf_wr_en, rf_wregno, rf_wrval); end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL lu_q_count_0 got=%0d exp=0", q_count); end
    clk_step();
    $display("test_lu_idle done");
  endtask

  task automatic test_full_starve();
    int n;
    pipe_wr_en = 1'b1; pipe_wregno = 5'd9; pipe_regval = 32'h9999;
    for (int k = 0; k < 4; k++) begin
      lu_valid = 1'b1; lu_wregno = 5'(k + 1); lu_regval = 32'h100 + 32'(k);
      clk_step();
    end
    n_checks++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL full_q_count got=%0d exp=4", q_count); end
    n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_lu_ready got=%b exp=0", lu_ready); end
    lu_wregno = 5'd5; lu_regval = 32'h555;
    clk_step();
    lu_valid = 1'b0;
    #1;
    n_checks++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_push got=%0d exp=4", q_count); end
    n_checks++; if (rf_wregno !== 5'd9) begin n_fail++; $display("FAIL full_pipe_priority got=%0d exp=9", rf_wregno); end
    n = 4;
    while (!pipe_stall && n < 20) begin
      clk_step();
      n++;
    end
    n_checks++; if (n != SL) begin n_fail++; $display("FAIL starve_wait got=%0d exp=%0d stall=%b", n, SL, pipe_stall); end
    n_checks++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall got=%b exp=1", pipe_stall); end
    clk_step();
    n_checks++; if (rf_wr_en !== 1'b1 || rf_wregno !== 5'd1 || rf_wrval !== 32'h100) begin
      n_fail++; $display("FAIL starve_lu_write got=%b/%0d/%h exp=1/1/100", rf_wr_en, rf_wregno, rf_wrval); end
    n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release got=%b exp=0", pipe_stall); end
    clk_step();
    n_checks++; if (rf_wr_en !== 1'b1 || rf_wregno !== 5'd9 || rf_wrval !== 32'h9999) begin
      n_fail++; $display("FAIL starve_pipe_lands got=%b/%0d/%h exp=1/9/9999", rf_wr_en, rf_wregno, rf_wrval); end
    pipe_wr_en = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      clk_step();
      n_checks++; if (rf_wregno !== 5'(k) || rf_wrval !== 32'h100 + 32'(k - 1)) begin
        n_fail++; $display("FAIL drain_order got=%0d/%h exp=%0d/%h", rf_wregno, rf_wrval, k, 32'h100 + 32'(k - 1)); end
    end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL drain_empty got=%0d exp=0", q_count); end
    clk_step();
    $display("test_full_starve done");
  endtask

  task automatic test_x0_fwd();
    pipe_wr_en = 1'b1; pipe_wregno = 5'd9; pipe_regval = 32'h1;
    lu_valid = 1'b1; lu_wregno = 5'd6; lu_regval = 32'h66;
    clk_step();
    lu_wregno = 5'd0; lu_regval = 32'h77;
    #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%b exp=1", lu_ready); end
    clk_step();
    n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL x0_q_count got=%0d exp=1", q_count); end
    lu_wregno = 5'd3; lu_regval = 32'd1;
    clk_step();
    lu_regval = 32'd2;
    clk_step();
    lu_valid = 1'b0;
    #1;
    n_checks++; if (q_count !== 3'd3) begin n_fail++; $display("FAIL fwdfill_q_count got=%0d exp=3", q_count); end
`ifdef WBARB_FWD_EN
    fwd_regno = 5'd3; #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_val !== 32'd2) begin n_fail++; $display("FAIL fwd_x3 got=%b/%h exp=1/2", fwd_hit, fwd_val); end
    fwd_regno = 5'd6; #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_val !== 32'h66) begin n_fail++; $display("FAIL fwd_x6 got=%b/%h exp=1/66", fwd_hit, fwd_val); end
    fwd_regno = 5'd4; #1;
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss got=%b exp=0", fwd_hit); end
    fwd_regno = 5'd0; #1;
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_x0 got=%b exp=0", fwd_hit); end
`endif
    pipe_wr_en = 1'b0;
    for (int i = 0; i < 6; i++) clk_step();
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL x0_drain got=%0d exp=0", q_count); end
    $display("test_x0_fwd done");
  endtask

  task automatic test_random();
    bit                   m_stall;
    bit                   hit;
    logic [DBITS-1:0]     hval;
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 79) == 0);
      pipe_wr_en  = ($urandom_range(0, 9) < 8);
      pipe_wregno = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_regval = $urandom;
      lu_valid    = ($urandom_range(0, 2) == 0);
      lu_wregno   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lu_regval   = $urandom;
`ifdef WBARB_FWD_EN
      fwd_regno   = 5'($urandom_range(0, 31));
`endif
      #1;
      if (!reset) begin
        m_stall = (m_age == SL) && (mq.size() > 0) && pipe_wr_en;
        n_checks++; if (pipe_stall !== m_stall) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, pipe_stall, m_stall); end
        n_checks++; if (lu_ready !== (mq.size() < QD)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, lu_ready, mq.size() < QD); end
        n_checks++; if (q_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_q_count cyc=%0d got=%0d exp=%0d", c, q_count, mq.size()); end
`ifdef WBARB_FWD_EN
        hit = 1'b0; hval = '0;
        for (int i = 0; i < mq.size(); i++) begin
          if (fwd_regno != 0 && mq[i].wregno == fwd_regno) begin hit = 1'b1; hval = mq[i].regval; end
        end
        n_checks++; if (fwd_hit !== hit || (hit && fwd_val !== hval)) begin
          n_fail++; $display("FAIL rnd_fwd cyc=%0d got=%b/%h exp=%b/%h", c, fwd_hit, fwd_val, hit, hval); end
`else
        hit = 1'b0; hval = '0;
`endif
      end
      clk_step();
      n_checks++; if (rf_wr_en !== m_en || rf_wregno !== m_regno || rf_wrval !== m_val) begin
        n_fail++; $display("FAIL rnd_rf cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_wr_en, rf_wregno, rf_wrval, m_en, m_regno, m_val); end
    end
    reset = 1'b0;
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_idle();
    test_pipe_only();
    test_lu_idle();
    test_full_starve();
    test_x0_fwd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback (WB stage results);
  - a long-latency unit (LU, e.g. multiply/divide), which completes out of band.
- LU results are buffered in a small FIFO. The pipeline has priority, with an age-based anti-starvation override.
- Sits between the WB stage / LU and the register file in the DE stage. Its registered output drives the register-file write.

Parameters:
- DBITS, 32, data width of a register value
- REGNOBITS, 5, register index width
- QDEPTH, 4, LU result FIFO depth (power of two, >= 2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before forcing an LU slot

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pipe_wr_en  in  1  pipeline WB requests a register write this cycle
- pipe_wregno  in  REGNOBITS  pipeline destination register
- pipe_regval  in  DBITS  pipeline write data
- pipe_stall  out  1  pipeline write not taken this cycle; WB holds its instruction
- lu_valid  in  1  LU presents a result
- lu_wregno  in  REGNOBITS  LU destination register
- lu_regval  in  DBITS  LU result data
- lu_ready  out  1  FIFO can accept a result this cycle
- rf_wr_en  out  1  register-file write enable
- rf_wregno  out  REGNOBITS  register-file write index
- rf_wrval  out  DBITS  register-file write data
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FIFO empty, q_count=0, age=0, rf_wr_en=0, rf_wregno=0, rf_wrval=0. lu_ready=1 after reset. pipe_stall=0 while the FIFO is empty.
- Reset asserted mid-operation discards all buffered LU results; no write issues in the reset cycle.
- FIFO:
  - lu_ready = (q_count < QDEPTH). It depends on registered count only, so no push is accepted at full, even with a same-cycle pop.
  - Push when lu_valid && lu_ready.
  - lu_wregno==0 is accepted (handshake completes) but not enqueued.
  - Pointers wrap modulo QDEPTH.
  - A push and pop in the same cycle leave q_count unchanged.
- Age counter:
  - Counts cycles the FIFO head was non-empty but not granted.
  - Resets to 0 on every pop and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Grant (combinational, evaluated each cycle):
  - force = (age == STARVE_LIMIT) && !empty.
  - If force: LU head is granted, and pipe_stall = pipe_wr_en.
  - Else if pipe_wr_en && pipe_wregno != 0: pipeline is granted, pipe_stall=0.
  - Else if !empty: LU head is granted (pop).
  - Else: no write.
  - pipe_wr_en with pipe_wregno==0: treated as accepted with no write; the LU may take the slot.
- Latency:
  - The granted write appears on the rf_* outputs one cycle after grant (registered).
  - rf_wr_en=0 in cycles with no grant; rf_wregno/rf_wrval hold their last values.
  - An LU push reaches the port no earlier than 2 cycles after acceptance (enqueue, then grant, then registered output).
- Ordering:
  - LU results retire in FIFO order.
  - Hazards between pipeline and LU writes to the same register are prevented by issue logic. The arbiter does not reorder or check them.

Optional Feature:
- Macro: WBARB_FWD_EN.
- When defined, adds ports:
  - fwd_regno  in  REGNOBITS
  - fwd_hit  out  1
  - fwd_val  out  DBITS
- fwd_hit is 1 when any valid FIFO entry matches fwd_regno (nonzero). fwd_val is the data of the youngest matching entry. Both are combinational.
- When undefined: ports are absent and the FIFO has no associative compare logic.

Decomposition:
- Shared package (define.vh), beside the existing constants:
  - DBITS and REGNOBITS;
  - the WB-to-DE bundle width;
  - a packed write-request typedef {wr_en, wregno, regval}.
- One sub-module: wb_lu_fifo, holding storage, pointers, count, and the optional forwarding compare.
- Grant, age counter and output register remain in wb_port_arbiter.

Test Plan:
- Reset, then idle: no requests for 5 cycles -> rf_wr_en=0, lu_ready=1, q_count=0, pipe_stall=0.
- Pipeline-only traffic: pipe_wr_en with x5=0x1234 -> next cycle rf_wr_en=1, rf_wregno=5, rf_wrval=0x1234; pipe_stall never asserted.
- LU into idle port: push x7=0xABCD -> grant next cycle, then rf write of x7=0xABCD 2 cycles after push; q_count returns to 0.
- Full FIFO with continuous pipe_wr_en: 4 LU pushes -> lu_ready=0 with q_count=4; a 5th lu_valid is not accepted.
- Starvation override (same stream as the full-FIFO case):
  - the head waits 8 cycles; on the next cycle pipe_stall=1 and the LU head is written;
  - the stalled pipe write lands one cycle later.
- Forwarding and x0 handling (WBARB_FWD_EN):
  - FIFO holds x3=1 then x3=2; fwd_regno=3 -> fwd_hit=1, fwd_val=2.
  - An LU push to x0 -> handshake completes, q_count unchanged.
